// File: rtl/pipeline_pause_ctrl_pkg.sv
// Shared stage indices, FSM encoding and the stall-request -> pause vector mapping
// for the 6-stage pipeline pause controller.
package pipeline_pause_ctrl_pkg;

  localparam int PAUSE_W   = 6;
  localparam int PAUSE_PC  = 0;
  localparam int PAUSE_IF  = 1;
  localparam int PAUSE_ID  = 2;
  localparam int PAUSE_EX  = 3;
  localparam int PAUSE_MEM = 4;
  localparam int PAUSE_WB  = 5;

  typedef logic [PAUSE_W-1:0] pause_t;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;

  // req[4]=MEM .. req[1]=IF; the oldest stalled stage freezes itself and everything younger.
  function automatic pause_t pause_mask(input logic [4:1] req);
    pause_t m;
    m = '0;
    casez (req)
      4'b1???: m = 6'b011111;
      4'b01??: m = 6'b001111;
      4'b001?: m = 6'b000111;
      4'b0001: m = 6'b000011;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pipeline_pause_ctrl_if.sv
// Stall/redirect request bundle in from the stages, pause/flush/redirect out to them.
interface pipeline_pause_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  import pipeline_pause_ctrl_pkg::*;

  logic                 stall_req_if;
  logic                 stall_req_id;
  logic                 stall_req_ex;
  logic                 stall_req_mem;
  logic                 branch_req;
  logic [PC_WIDTH-1:0]  branch_target;
  logic                 exc_req;
  logic [PC_WIDTH-1:0]  exc_target;
  pause_t               pause;
  logic                 flush;
  logic [PC_WIDTH-1:0]  new_pc;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic                 stall_timeout;

  modport master (
    output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
           branch_req, branch_target, exc_req, exc_target,
    input  pause, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
           branch_req, branch_target, exc_req, exc_target,
    output pause, flush, new_pc, stall_cycles, stall_timeout
  );

endinterface

// File: rtl/pipeline_pause_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and raises a sticky timeout after MAX_STALL of them.
module pipeline_pause_ctrl_stall_watchdog #(
  parameter int MAX_STALL = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  input  logic clear,
  output logic timeout
);

  localparam int CW = $clog2(MAX_STALL + 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (clear || !stalled) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(MAX_STALL)) begin
      cnt_q <= cnt_q + 1'b1;
      // Flag goes up on the same edge the count reaches MAX_STALL.
      if (cnt_q == CW'(MAX_STALL - 1))
        timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_pause_ctrl.sv
// Central stall/flush controller: combinational pause vector, registered one-cycle
// flush with redirect PC, saturating stall counter and stall watchdog.
module pipeline_pause_ctrl
  import pipeline_pause_ctrl_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_STALL = 1024
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_pause_ctrl_if.slave bus
);

  ctrl_state_e          state_q;
  logic                 flush_q;
  logic [PC_WIDTH-1:0]  new_pc_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  pause_t               pause;
  logic                 stalled;
  logic                 exc_ok;
  logic                 br_ok;
  logic                 timeout;

  // A redirect is only taken once its source stage is no longer frozen.
  always_comb begin
    pause = '0;
    if (!rst && state_q == CTRL_RUN)
      pause = pause_mask({bus.stall_req_mem, bus.stall_req_ex, bus.stall_req_id, bus.stall_req_if});
    stalled = |pause;
    exc_ok  = bus.exc_req    && !pause[PAUSE_MEM];
    br_ok   = bus.branch_req && !pause[PAUSE_EX];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CTRL_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      case (state_q)
        CTRL_RUN: begin
          if (exc_ok) begin
            new_pc_q <= bus.exc_target;
            flush_q  <= 1'b1;
            state_q  <= CTRL_FLUSH;
          end else if (br_ok) begin
            new_pc_q <= bus.branch_target;
            flush_q  <= 1'b1;
            state_q  <= CTRL_FLUSH;
          end
        end
        CTRL_FLUSH: begin
          flush_q <= 1'b0;
          state_q <= CTRL_RUN;
        end
        default: begin
          flush_q <= 1'b0;
          state_q <= CTRL_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stalled && state_q == CTRL_RUN && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  pipeline_pause_ctrl_stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_stall_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stalled (stalled),
    .clear   (state_q == CTRL_FLUSH),
    .timeout (timeout)
  );

  assign bus.pause         = pause;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_cycles  = stall_cnt_q;
  assign bus.stall_timeout = timeout;

endmodule

// File: doc/pipeline_pause_ctrl.md
Name: pipeline_pause_ctrl

Overview:
Central stall/flush controller for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB). It is the producer of the pause vector consumed by every inter-stage register.
- Collects per-stage stall requests and branch/exception redirect requests.
- Drives pause[5:0], a one-cycle flush pulse and the redirect PC.
- Keeps a saturating stall-cycle performance counter and a sticky stall watchdog flag.

Parameters:
PC_WIDTH, 32, width of branch/exception targets and new_pc.
CNT_WIDTH, 32, width of stall_cycles perf counter.
MAX_STALL, 1024, consecutive stalled cycles that trip stall_timeout (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
stall_req_if  input  1  IF stage cannot advance.
stall_req_id  input  1  ID stage cannot advance.
stall_req_ex  input  1  EX stage cannot advance (multi-cycle mul/div).
stall_req_mem  input  1  MEM stage cannot advance (data access pending).
branch_req  input  1  EX resolved a taken/mispredicted branch.
branch_target  input  PC_WIDTH  redirect PC for branch_req.
exc_req  input  1  MEM raised an exception/ertn.
exc_target  input  PC_WIDTH  redirect PC for exc_req.
pause  output  6  bit k freezes stage k output register; [0]=PC … [5]=WB.
flush  output  1  registered one-cycle kill of all in-flight younger instructions.
new_pc  output  PC_WIDTH  registered redirect target, valid while flush=1.
stall_cycles  output  CNT_WIDTH  cycles with pause!=0, saturating.
stall_timeout  output  1  sticky: stall held MAX_STALL consecutive cycles.

Behaviour:
- Reset (async, immediate): state=RUN, flush=0, new_pc=0, stall_cycles=0, stall_timeout=0, consecutive counter=0; pause=0 while rst=1.
- pause is combinational, same-cycle:
  - k = highest requesting stage (IF=1, ID=2, EX=3, MEM=4); pause = bits k..0 set, e.g. MEM -> 6'b011111, IF -> 6'b000011.
  - No request -> 6'b000000. pause[5] is always 0.
  - Consumers insert a bubble where pause[k]=1 and pause[k+1]=0.
- FSM, 2 states:
  - RUN:
    - Accept exc_req only when pause[4]=0. Accept branch_req only when pause[3]=0 (the branch is still held in EX otherwise; the requester keeps it asserted).
    - exc_req has priority over branch_req in the same cycle.
    - On acceptance: new_pc <= selected target; flush <= 1; next state FLUSH.
  - FLUSH, exactly one cycle:
    - flush=1, pause forced to 0 regardless of requests.
    - branch_req/exc_req ignored; they come from instructions being killed.
    - Next state RUN, flush <= 0. new_pc holds its value until the next acceptance.
- Back-to-back redirects: a request in the cycle immediately after FLUSH is accepted normally, so the minimum spacing between flush pulses is 2 cycles.
- stall_cycles:
  - +1 each RUN cycle with pause!=0.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Watchdog:
  - Consecutive counter +1 per cycle with pause!=0; cleared to 0 when pause=0 or in FLUSH.
  - When it reaches MAX_STALL, stall_timeout <= 1 (sticky until rst); the counter then saturates.
- Reset mid-FLUSH: flush drops immediately and the pending redirect is lost.

Decomposition:
- Shared define.v:
  - `PauseWidth (5:0).
  - Stage index macros PAUSE_PC=0, PAUSE_IF=1, PAUSE_ID=2, PAUSE_EX=3, PAUSE_MEM=4, PAUSE_WB=5.
  - `InstAddrWidth for PC width.
  - FSM state encodings CTRL_RUN=1'b0, CTRL_FLUSH=1'b1.
- One sub-module, stall_watchdog: consecutive counter plus sticky flag, parameter MAX_STALL, inputs clk/rst/stalled/clear, output timeout.

Test Plan:
- rst=1 with all requests high -> pause=0, flush=0, new_pc=0, counters 0. Release rst with stall_req_mem=1 -> pause=6'b011111 the same cycle.
- stall_req_if=1 and stall_req_ex=1 together -> pause=6'b001111. Drop stall_req_ex -> 6'b000011. Drop stall_req_if -> 0.
- branch_req=1, branch_target=0x1C000040, no stalls -> next cycle flush=1, new_pc=0x1C000040, pause=0. Following cycle flush=0.
- exc_req (target 0x1C008000) and branch_req (target 0x1C000040) in the same cycle -> new_pc=0x1C008000, single flush pulse.
- branch_req=1 while stall_req_mem=1 for 3 cycles -> no flush during the stall. Flush occurs the cycle after stall_req_mem drops. stall_cycles=3.
- MAX_STALL=4, stall_req_id held 4 cycles -> stall_timeout=1 after the 4th edge and stays 1 after the stall clears. Holding stall 2^CNT_WIDTH cycles (CNT_WIDTH=4) -> stall_cycles sticks at 4'hF.
